// File: rtl/fir_y_reader.sv
// fir_y_reader
//   Consumer end of the FIR output stream. After each st pulse it captures
//   up to DEPTH filter outputs (y_out qualified by y_vld) into a small
//   buffer. The operator then steps through the buffer with the sw button,
//   and half_data shows the low or high byte of the selected sample.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   st         one-cycle start pulse: clear the buffer, begin a capture
//   y_out      filter output sample, valid when y_vld=1
//   y_vld      one-cycle strobe per output sample
//   sw         raw step button (asynchronous level input)
//   sel        byte select: 0 = y[7:0], 1 = y[15:8]
//   half_data  registered selected byte of mem[idx]
//   idx        current read pointer
//   cnt        number of samples captured (0..DEPTH)
//   full       cnt == DEPTH
//   rd_done    sticky: read pointer has wrapped since the last st
//   busy       high while capturing
//   cksum      running 16-bit sum of captured samples
//              (present only when FIR_RDR_CKSUM_EN is defined)
//
// Optional feature macro: FIR_RDR_CKSUM_EN
module fir_y_reader #(
    parameter int Y_W   = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            st,
    input  logic [Y_W-1:0]  y_out,
    input  logic            y_vld,
    input  logic            sw,
    input  logic            sel,
    output logic [7:0]      half_data,
    output logic [AW-1:0]   idx,
    output logic [AW:0]     cnt,
    output logic            full,
    output logic            rd_done,
    output logic            busy
`ifdef FIR_RDR_CKSUM_EN
    ,
    output logic [15:0]     cksum
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READ    = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            full_q, full_d;
    logic            rd_done_q, rd_done_d;
    logic [7:0]      half_data_q, half_data_d;
    logic            sw_s1_q, sw_s2_q, sw_s3_q;
    logic            sw_edge;
    logic            we;
    logic [Y_W-1:0]  rd_word;
    logic [AW:0]     last_idx;

`ifdef FIR_RDR_CKSUM_EN
    logic [15:0]     cksum_q, cksum_d;
`endif

    // Capture buffer; contents are don't-care until written, so no reset.
    logic [Y_W-1:0]  mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[cnt_q[AW-1:0]] <= y_out;
        end
    end

    assign rd_word  = mem[idx_q];
    // One rising-edge pulse per press, taken after the two-flop synchronizer.
    assign sw_edge  = sw_s2_q & ~sw_s3_q;
    assign last_idx = cnt_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        full_d      = full_q;
        rd_done_d   = rd_done_q;
        half_data_d = half_data_q;
        we          = 1'b0;
`ifdef FIR_RDR_CKSUM_EN
        cksum_d     = cksum_q;
`endif

        if (state_q != IDLE) begin
            half_data_d = sel ? rd_word[15:8] : rd_word[7:0];
        end

        // st wins over any y_vld or sw edge in the same cycle.
        if (st) begin
            state_d   = CAPTURE;
            cnt_d     = '0;
            idx_d     = '0;
            rd_done_d = 1'b0;
            full_d    = 1'b0;
`ifdef FIR_RDR_CKSUM_EN
            cksum_d   = '0;
`endif
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (y_vld) begin
                        we    = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        // While capturing, idx follows the last written slot.
                        idx_d = cnt_q[AW-1:0];
`ifdef FIR_RDR_CKSUM_EN
                        cksum_d = cksum_q + y_out;
`endif
                        if (cnt_q == CNT_LAST) begin
                            full_d  = 1'b1;
                            state_d = READ;
                            idx_d   = '0;
                        end
                    end
                    // Partial capture: a sample arriving with the press is still kept.
                    if (sw_edge && (cnt_q != '0)) begin
                        state_d = READ;
                        idx_d   = '0;
                    end
                end
                READ: begin
                    if (sw_edge) begin
                        if ({1'b0, idx_q} == last_idx) begin
                            idx_d     = '0;
                            rd_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            full_q      <= 1'b0;
            rd_done_q   <= 1'b0;
            half_data_q <= '0;
            sw_s1_q     <= 1'b0;
            sw_s2_q     <= 1'b0;
            sw_s3_q     <= 1'b0;
`ifdef FIR_RDR_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            full_q      <= full_d;
            rd_done_q   <= rd_done_d;
            half_data_q <= half_data_d;
            sw_s1_q     <= sw;
            sw_s2_q     <= sw_s1_q;
            sw_s3_q     <= sw_s2_q;
`ifdef FIR_RDR_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign half_data = half_data_q;
    assign idx       = idx_q;
    assign cnt       = cnt_q;
    assign full      = full_q;
    assign rd_done   = rd_done_q;
    assign busy      = (state_q == CAPTURE);
`ifdef FIR_RDR_CKSUM_EN
    assign cksum     = cksum_q;
`endif

endmodule
